// File: rtl/deser_pkg.sv
// Shared constants and types for the 1-bit serial link deserializer.
package deser_pkg;

    localparam int unsigned DESER_NBITS = 8;
    localparam int unsigned DESER_IDX_W = 3;

    typedef logic [DESER_IDX_W-1:0] deser_idx_t;

    localparam deser_idx_t DESER_IDX_LAST = 3'd7;

    // Byte position that the k-th serial bit occupies.
    function automatic deser_idx_t deser_bit_pos(input deser_idx_t k, input bit lsb_first);
        return lsb_first ? k : deser_idx_t'(DESER_IDX_LAST - k);
    endfunction

endpackage

// File: rtl/deser8_1b_if.sv
// Serial-in / byte-out handshake bundle of the deserializer.
interface deser8_1b_if;
    import deser_pkg::*;

    logic                   clear;
    logic                   in_val;
    logic                   in_rdy;
    logic                   in_bit;
    logic                   out_val;
    logic                   out_rdy;
    logic [DESER_NBITS-1:0] out_data;
    deser_idx_t             idx;

    modport master (
        output clear, in_val, in_bit, out_rdy,
        input  in_rdy, out_val, out_data, idx
    );

    modport slave (
        input  clear, in_val, in_bit, out_rdy,
        output in_rdy, out_val, out_data, idx
    );

endinterface

// File: rtl/deser_out_buf.sv
// One-entry val/rdy register slice holding the last completed byte.
module deser_out_buf
    import deser_pkg::*;
#(
    parameter int unsigned Width = DESER_NBITS
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    input  logic             rdy_i,
    output logic             val_o,
    output logic [Width-1:0] data_o
);

    logic             val_q, val_d;
    logic [Width-1:0] data_q, data_d;

    // A load in the same cycle as a drain replaces the byte and keeps val high.
    always_comb begin
        val_d  = val_q;
        data_d = data_q;
        if (val_q && rdy_i) begin
            val_d = 1'b0;
        end
        if (load_i) begin
            val_d  = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            val_q  <= 1'b0;
            data_q <= '0;
        end else begin
            val_q  <= val_d;
            data_q <= data_d;
        end
    end

    assign val_o  = val_q;
    assign data_o = data_q;

endmodule

// File: rtl/deser8_1b.sv
// Deserializer top: collects 8 serial bits into a byte and hands it to the output slice.
module deser8_1b
    import deser_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input logic        clk,
    input logic        rst_n,
    deser8_1b_if.slave bus
);

    logic [DESER_NBITS-1:0] asm_q, asm_d;
    logic [DESER_NBITS-1:0] load_data;
    deser_idx_t             idx_q, idx_d;
    deser_idx_t             pos;
    logic                   is_last;
    logic                   in_rdy;
    logic                   bit_xfer;
    logic                   load;
    logic                   buf_val;
    logic [DESER_NBITS-1:0] buf_data;

    always_comb begin
        is_last   = (idx_q == DESER_IDX_LAST);
        pos       = deser_bit_pos(idx_q, LSB_FIRST);
        // Only the final bit can stall: it needs the output slice free or draining.
        in_rdy    = rst_n && !bus.clear && (!is_last || !buf_val || bus.out_rdy);
        bit_xfer  = bus.in_val && in_rdy;
        load_data = asm_q;
        load_data[pos] = bus.in_bit;

        asm_d = asm_q;
        idx_d = idx_q;
        load  = 1'b0;
        if (bus.clear) begin
            asm_d = '0;
            idx_d = '0;
        end else if (bit_xfer) begin
            if (is_last) begin
                load  = 1'b1;
                asm_d = '0;
                idx_d = '0;
            end else begin
                asm_d = load_data;
                idx_d = deser_idx_t'(idx_q + 3'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_q <= '0;
            idx_q <= '0;
        end else begin
            asm_q <= asm_d;
            idx_q <= idx_d;
        end
    end

    deser_out_buf #(
        .Width (DESER_NBITS)
    ) u_out_buf (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .load_i (load),
        .data_i (load_data),
        .rdy_i  (bus.out_rdy),
        .val_o  (buf_val),
        .data_o (buf_data)
    );

    assign bus.in_rdy   = in_rdy;
    assign bus.out_val  = buf_val;
    assign bus.out_data = buf_data;
    assign bus.idx      = idx_q;

endmodule

// File: tb/tb_deser8_1b.sv
// Directed self-checking bench for deser8_1b (LSB-first and MSB-first instances).
module tb_deser8_1b;
    import deser_pkg::*;

    logic clk = 1'b0;
    logic rst_n, clear, in_val, in_bit, out_rdy;
    int   total = 0;
    int   bad = 0;
    int   xfer_cnt = 0;

    deser8_1b_if bus0 ();
    deser8_1b_if bus1 ();

    assign bus0.clear   = clear;
    assign bus0.in_val  = in_val;
    assign bus0.in_bit  = in_bit;
    assign bus0.out_rdy = out_rdy;
    assign bus1.clear   = clear;
    assign bus1.in_val  = in_val;
    assign bus1.in_bit  = in_bit;
    assign bus1.out_rdy = out_rdy;

    deser8_1b #(.LSB_FIRST(1'b1)) u_dut_lsb (.clk(clk), .rst_n(rst_n), .bus(bus0));
    deser8_1b #(.LSB_FIRST(1'b0)) u_dut_msb (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bus0.out_val && bus0.out_rdy) xfer_cnt <= xfer_cnt + 1;
    end

    // Drives n consecutive bits of b starting at bit 0; call at a negedge.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            in_val = 1'b1;
            in_bit = b[k];
            @(negedge clk);
        end
        in_val = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_val = 1'b1; in_bit = 1'b1; out_rdy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            total++; if (bus0.in_rdy !== 1'b0) begin bad++;
                $display("FAIL rst_in_rdy_low: got %b want 0", bus0.in_rdy); end
        end
        rst_n = 1'b1; in_val = 1'b0; #1;
        total++; if (bus0.idx !== 3'd0) begin bad++;
            $display("FAIL rst_idx: got %0d want 0", bus0.idx); end
        total++; if (bus0.out_val !== 1'b0) begin bad++;
            $display("FAIL rst_out_val: got %b want 0", bus0.out_val); end
        total++; if (bus0.out_data !== 8'h00) begin bad++;
            $display("FAIL rst_out_data: got %h want 00", bus0.out_data); end
        total++; if (bus0.in_rdy !== 1'b1) begin bad++;
            $display("FAIL rst_in_rdy_high: got %b want 1", bus0.in_rdy); end
    endtask

    task automatic test_single_byte();
        logic [7:0] b;
        b = 8'h25;
        out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_val = 1'b1; in_bit = b[k];
            @(negedge clk);
            if (k < 7) begin
                total++; if (bus0.out_val !== 1'b0) begin bad++;
                    $display("FAIL single_early_val k=%0d: got %b want 0", k, bus0.out_val); end
                total++; if (bus0.idx !== deser_idx_t'(k + 1)) begin bad++;
                    $display("FAIL single_idx k=%0d: got %0d want %0d", k, bus0.idx, k + 1); end
            end
        end
        in_val = 1'b0;
        total++; if (bus0.out_val !== 1'b1) begin bad++;
            $display("FAIL single_val: got %b want 1", bus0.out_val); end
        total++; if (bus0.out_data !== 8'h25) begin bad++;
            $display("FAIL single_lsb_data: got %h want 25", bus0.out_data); end
        total++; if (bus1.out_data !== 8'hA4) begin bad++;
            $display("FAIL single_msb_data: got %h want a4", bus1.out_data); end
        total++; if (bus0.idx !== 3'd0) begin bad++;
            $display("FAIL single_idx_wrap: got %0d want 0", bus0.idx); end
        @(negedge clk);
        total++; if (bus0.out_val !== 1'b0) begin bad++;
            $display("FAIL single_val_drop: got %b want 0", bus0.out_val); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        w = 16'hC75A;
        out_rdy = 1'b1;
        for (int j = 0; j < 16; j++) begin
            in_val = 1'b1; in_bit = w[j];
            @(negedge clk);
            total++; if (bus0.out_val !== ((j == 7) || (j == 15))) begin bad++;
                $display("FAIL b2b_val j=%0d: got %b", j, bus0.out_val); end
            if (j == 7) begin
                total++; if (bus0.out_data !== 8'h5A) begin bad++;
                    $display("FAIL b2b_byte0: got %h want 5a", bus0.out_data); end
            end
            if (j == 15) begin
                total++; if (bus0.out_data !== 8'hC7) begin bad++;
                    $display("FAIL b2b_byte1: got %h want c7", bus0.out_data); end
            end
        end
        in_val = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [7:0] b;
        int         base;
        b = 8'hC3;
        out_rdy = 1'b0;
        send_bits(8'h3C, 8);
        total++; if (bus0.out_val !== 1'b1 || bus0.out_data !== 8'h3C) begin bad++;
            $display("FAIL bp_first: got val=%b data=%h want 1/3c", bus0.out_val, bus0.out_data); end
        send_bits(b, 7);
        total++; if (bus0.idx !== 3'd7) begin bad++;
            $display("FAIL bp_idx7: got %0d want 7", bus0.idx); end
        in_val = 1'b1; in_bit = b[7]; #1;
        total++; if (bus0.in_rdy !== 1'b0) begin bad++;
            $display("FAIL bp_stall_rdy: got %b want 0", bus0.in_rdy); end
        @(negedge clk);
        total++; if (bus0.idx !== 3'd7 || bus0.out_data !== 8'h3C) begin bad++;
            $display("FAIL bp_hold: got idx=%0d data=%h want 7/3c", bus0.idx, bus0.out_data); end
        base = xfer_cnt;
        out_rdy = 1'b1; #1;
        total++; if (bus0.in_rdy !== 1'b1) begin bad++;
            $display("FAIL bp_release_rdy: got %b want 1", bus0.in_rdy); end
        @(negedge clk);
        out_rdy = 1'b0; in_val = 1'b0;
        total++; if (bus0.out_val !== 1'b1 || bus0.out_data !== 8'hC3) begin bad++;
            $display("FAIL bp_replace: got val=%b data=%h want 1/c3", bus0.out_val, bus0.out_data); end
        total++; if (xfer_cnt - base !== 1) begin bad++;
            $display("FAIL bp_handoff: got %0d want 1", xfer_cnt - base); end
        total++; if (bus0.idx !== 3'd0) begin bad++;
            $display("FAIL bp_idx0: got %0d want 0", bus0.idx); end
        out_rdy = 1'b1;
        @(negedge clk);
        total++; if (bus0.out_val !== 1'b0 || xfer_cnt - base !== 2) begin bad++;
            $display("FAIL bp_drain: got val=%b xfers=%0d want 0/2", bus0.out_val, xfer_cnt - base); end
    endtask

    task automatic test_gapped();
        logic [7:0] b;
        int         base;
        int         gap;
        b = 8'h96;
        out_rdy = 1'b1;
        base = xfer_cnt;
        for (int k = 0; k < 8; k++) begin
            in_val = 1'b1; in_bit = b[k];
            @(negedge clk);
            in_val = 1'b0;
            if (k < 7) begin
                gap = int'($urandom_range(0, 3));
                for (int g = 0; g <= gap; g++) begin
                    total++; if (bus0.idx !== deser_idx_t'(k + 1)) begin bad++;
                        $display("FAIL gap_idx k=%0d: got %0d want %0d", k, bus0.idx, k + 1); end
                    if (g < gap) @(negedge clk);
                end
            end
        end
        total++; if (bus0.out_val !== 1'b1 || bus0.out_data !== 8'h96) begin bad++;
            $display("FAIL gap_data: got val=%b data=%h want 1/96", bus0.out_val, bus0.out_data); end
        repeat (3) @(negedge clk);
        total++; if (xfer_cnt - base !== 1 || bus0.out_val !== 1'b0) begin bad++;
            $display("FAIL gap_xfers: got %0d val=%b want 1/0", xfer_cnt - base, bus0.out_val); end
    endtask

    task automatic test_clear();
        int base;
        out_rdy = 1'b1;
        send_bits(8'hFF, 4);
        total++; if (bus0.idx !== 3'd4) begin bad++;
            $display("FAIL clr_idx4: got %0d want 4", bus0.idx); end
        clear = 1'b1; in_val = 1'b1; in_bit = 1'b1; #1;
        total++; if (bus0.in_rdy !== 1'b0) begin bad++;
            $display("FAIL clr_rdy: got %b want 0", bus0.in_rdy); end
        @(negedge clk);
        clear = 1'b0; in_val = 1'b0;
        total++; if (bus0.idx !== 3'd0 || bus0.out_val !== 1'b0) begin bad++;
            $display("FAIL clr_idx0: got idx=%0d val=%b want 0/0", bus0.idx, bus0.out_val); end
        send_bits(8'h0F, 8);
        total++; if (bus0.out_val !== 1'b1 || bus0.out_data !== 8'h0F) begin bad++;
            $display("FAIL clr_lsb_data: got val=%b data=%h want 1/0f", bus0.out_val, bus0.out_data); end
        total++; if (bus1.out_data !== 8'hF0) begin bad++;
            $display("FAIL clr_msb_data: got %h want f0", bus1.out_data); end
        @(negedge clk);
        out_rdy = 1'b0;
        send_bits(8'h55, 8);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus0.out_val !== 1'b1 || bus0.out_data !== 8'h55) begin bad++;
            $display("FAIL clr_pending: got val=%b data=%h want 1/55", bus0.out_val, bus0.out_data); end
        base = xfer_cnt;
        out_rdy = 1'b1;
        @(negedge clk);
        total++; if (xfer_cnt - base !== 1 || bus0.out_val !== 1'b0) begin bad++;
            $display("FAIL clr_deliver: got %0d val=%b want 1/0", xfer_cnt - base, bus0.out_val); end
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b0;
        send_bits(8'hAA, 8);
        send_bits(8'h81, 5);
        total++; if (bus0.idx !== 3'd5 || bus0.out_data !== 8'hAA) begin bad++;
            $display("FAIL mid_pre: got idx=%0d data=%h want 5/aa", bus0.idx, bus0.out_data); end
        rst_n = 1'b0; #1;
        total++; if (bus0.in_rdy !== 1'b0) begin bad++;
            $display("FAIL mid_rdy: got %b want 0", bus0.in_rdy); end
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (bus0.out_val !== 1'b0 || bus0.idx !== 3'd0 || bus0.out_data !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset: got val=%b idx=%0d data=%h want 0/0/00",
                     bus0.out_val, bus0.idx, bus0.out_data);
        end
        out_rdy = 1'b1;
        send_bits(8'h81, 8);
        total++; if (bus0.out_val !== 1'b1 || bus0.out_data !== 8'h81) begin bad++;
            $display("FAIL mid_after: got val=%b data=%h want 1/81", bus0.out_val, bus0.out_data); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_backpressure();
        test_gapped();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
